// File: rtl/nf_instr_loader.sv
// nf_instr_loader: receives a framed byte stream and writes the payload into
// instruction memory as 32-bit little-endian words. The CPU is held stalled
// from the sync byte until a frame finishes with a good checksum.
module nf_instr_loader #(
  parameter int         DEPTH     = 64,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 1000000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        wr_en_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CHK} state_e;

  localparam logic [15:0] DEPTH_W  = 16'(DEPTH);
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        ready_q;
  logic [7:0]  cntLo_q, cntLo_d;
  logic [15:0] nWords_q, nWords_d;
  logic [1:0]  byteIdx_q, byteIdx_d;
  logic [15:0] wordCnt_q, wordCnt_d;
  logic [15:0] addrWord_q, addrWord_d;
  logic [31:0] wrData_q, wrData_d;
  logic        wrEn_q, wrEn_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  chkSum_q, chkSum_d;
  logic [19:0] tmo_q, tmo_d;

  logic        accept;
  logic [15:0] nIn;
  logic [15:0] wordNext;

  assign accept   = in_valid_i && ready_q;
  assign nIn      = {in_data_i, cntLo_q};
  assign wordNext = wordCnt_q + 16'd1;

  assign in_ready_o = ready_q;
  assign wr_addr_o  = {14'd0, addrWord_q, 2'b00};
  assign wr_data_o  = wrData_q;
  assign wr_en_o    = wrEn_q;
  assign cpu_hold_o = hold_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

  // State and datapath registers; everything clears immediately on reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      cntLo_q    <= '0;
      nWords_q   <= '0;
      byteIdx_q  <= '0;
      wordCnt_q  <= '0;
      addrWord_q <= '0;
      wrData_q   <= '0;
      wrEn_q     <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      chkSum_q   <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= 1'b1;
      cntLo_q    <= cntLo_d;
      nWords_q   <= nWords_d;
      byteIdx_q  <= byteIdx_d;
      wordCnt_q  <= wordCnt_d;
      addrWord_q <= addrWord_d;
      wrData_q   <= wrData_d;
      wrEn_q     <= wrEn_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      chkSum_q   <= chkSum_d;
      tmo_q      <= tmo_d;
    end
  end

  // Frame parser: next state, word assembly, write strobe, checksum and timeout.
  always_comb begin
    state_d    = state_q;
    cntLo_d    = cntLo_q;
    nWords_d   = nWords_q;
    byteIdx_d  = byteIdx_q;
    wordCnt_d  = wordCnt_q;
    addrWord_d = addrWord_q;
    wrData_d   = wrData_q;
    wrEn_d     = 1'b0;
    hold_d     = hold_q;
    done_d     = 1'b0;
    err_d      = err_q;
    chkSum_d   = chkSum_q;
    tmo_d      = tmo_q;

    // The address steps one cycle after each write strobe.
    if (wrEn_q) begin
      addrWord_d = addrWord_q + 16'd1;
    end

    // Inter-byte watchdog, only armed while inside a frame.
    if (state_q != IDLE) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_d   = '0;
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + 20'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (accept && in_data_i == SYNC_BYTE) begin
          state_d    = CNT_LO;
          hold_d     = 1'b1;
          err_d      = 1'b0;
          addrWord_d = '0;
          chkSum_d   = '0;
          tmo_d      = '0;
        end
      end
      CNT_LO: begin
        if (accept) begin
          cntLo_d = in_data_i;
          state_d = CNT_HI;
        end
      end
      CNT_HI: begin
        if (accept) begin
          nWords_d = nIn;
          if (nIn > DEPTH_W) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (nIn == 16'd0) begin
            state_d = CHK;
          end else begin
            byteIdx_d = '0;
            wordCnt_d = '0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          wrData_d[{byteIdx_q, 3'b000} +: 8] = in_data_i;
          chkSum_d  = chkSum_q + in_data_i;
          byteIdx_d = byteIdx_q + 2'd1;
          if (byteIdx_q == 2'd3) begin
            wrEn_d    = 1'b1;
            wordCnt_d = wordNext;
            if (wordNext == nWords_q) begin
              state_d = CHK;
            end
          end
        end
      end
      CHK: begin
        if (accept) begin
          if (in_data_i == chkSum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nf_instr_loader.sv
// tb_nf_instr_loader: directed frames against the loader with hand-computed
// expected writes, status flags and pulse counts.
module tb_nf_instr_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  inData;
  logic        inValid;
  logic        inReady;
  logic [31:0] wrAddr;
  logic [31:0] wrData;
  logic        wrEn;
  logic        cpuHold;
  logic        done;
  logic        err;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] wrAddrLog[$];
  logic [31:0] wrDataLog[$];
  int          doneCount = 0;

  // Nominal two-word frame without its checksum byte.
  // Data sum: 0x78+0x56+0x34+0x12+0xEF+0xBE+0xAD+0xDE = 0x44C -> checksum 0x4C.
  localparam logic [7:0] NOMINAL [11] = '{8'hA5, 8'h02, 8'h00,
                                          8'h78, 8'h56, 8'h34, 8'h12,
                                          8'hEF, 8'hBE, 8'hAD, 8'hDE};
  localparam logic [7:0] GOOD_CHK = 8'h4C;

  nf_instr_loader #(
    .DEPTH     (64),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (16)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .in_data_i  (inData),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .wr_addr_o  (wrAddr),
    .wr_data_o  (wrData),
    .wr_en_o    (wrEn),
    .cpu_hold_o (cpuHold),
    .done_o     (done),
    .err_o      (err)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Record every memory write and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (wrEn) begin
      wrAddrLog.push_back(wrAddr);
      wrDataLog.push_back(wrData);
    end
    if (done) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one byte for one cycle, then leave the link idle for gap cycles.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    inValid = 1'b1;
    inData  = b;
    @(negedge clk);
    inValid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendNominal(input logic [7:0] chk, input int gap);
    for (int i = 0; i < 11; i++) applyStimulus(NOMINAL[i], gap);
    applyStimulus(chk, 0);
  endtask

  task automatic checkNominalWrites(input string tag, input int base);
    checkOutput({tag, " write count"}, 32'(wrAddrLog.size() - base), 32'd2);
    if (wrAddrLog.size() >= base + 2) begin
      checkOutput({tag, " addr0"}, wrAddrLog[base],     32'h0);
      checkOutput({tag, " data0"}, wrDataLog[base],     32'h12345678);
      checkOutput({tag, " addr1"}, wrAddrLog[base + 1], 32'h4);
      checkOutput({tag, " data1"}, wrDataLog[base + 1], 32'hDEADBEEF);
    end
  endtask

  initial begin
    int base;
    int doneBase;
    reset   = 1'b1;
    inValid = 1'b0;
    inData  = 8'h00;

    // Reset values.
    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", 32'(inReady), 32'd0);
    checkOutput("reset wr_addr", wrAddr, 32'd0);
    checkOutput("reset wr_data", wrData, 32'd0);
    checkOutput("reset outputs", {28'd0, wrEn, cpuHold, done, err}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("in_ready after reset", 32'(inReady), 32'd1);

    // Garbage before sync is discarded, then a nominal frame.
    $display("[TB] nominal frame");
    base = wrAddrLog.size();
    doneBase = doneCount;
    applyStimulus(8'h00, 0);
    applyStimulus(8'hFF, 0);
    applyStimulus(8'h5A, 0);
    checkOutput("garbage hold", 32'(cpuHold), 32'd0);
    applyStimulus(NOMINAL[0], 0);
    checkOutput("hold at sync", 32'(cpuHold), 32'd1);
    for (int i = 1; i < 11; i++) applyStimulus(NOMINAL[i], 0);
    checkOutput("hold before chk", 32'(cpuHold), 32'd1);
    applyStimulus(GOOD_CHK, 0);
    checkOutput("done pulse", 32'(done), 32'd1);
    checkOutput("hold after chk", 32'(cpuHold), 32'd0);
    repeat (3) @(negedge clk);
    checkNominalWrites("nominal", base);
    checkOutput("nominal done count", 32'(doneCount - doneBase), 32'd1);
    checkOutput("nominal err", 32'(err), 32'd0);

    // Bad checksum: writes still happen, error sticks, CPU stays held.
    $display("[TB] bad checksum");
    base = wrAddrLog.size();
    doneBase = doneCount;
    sendNominal(8'h00, 0);
    repeat (3) @(negedge clk);
    checkNominalWrites("badchk", base);
    checkOutput("badchk err", 32'(err), 32'd1);
    checkOutput("badchk hold", 32'(cpuHold), 32'd1);
    checkOutput("badchk done count", 32'(doneCount - doneBase), 32'd0);
    sendNominal(GOOD_CHK, 0);
    repeat (3) @(negedge clk);
    checkOutput("recover err", 32'(err), 32'd0);
    checkOutput("recover hold", 32'(cpuHold), 32'd0);

    // Oversize count 0x41 > 64 words.
    $display("[TB] oversize count");
    base = wrAddrLog.size();
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h41, 0);
    applyStimulus(8'h00, 0);
    checkOutput("oversize err", 32'(err), 32'd1);
    checkOutput("oversize hold", 32'(cpuHold), 32'd1);
    applyStimulus(8'h00, 3);
    checkOutput("oversize err stays", 32'(err), 32'd1);
    checkOutput("oversize writes", 32'(wrAddrLog.size() - base), 32'd0);

    // Zero-length frame.
    $display("[TB] zero count");
    base = wrAddrLog.size();
    doneBase = doneCount;
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 3);
    checkOutput("zero writes", 32'(wrAddrLog.size() - base), 32'd0);
    checkOutput("zero done count", 32'(doneCount - doneBase), 32'd1);
    checkOutput("zero hold", 32'(cpuHold), 32'd0);
    checkOutput("zero err", 32'(err), 32'd0);

    // Timeout inside the data phase.
    $display("[TB] timeout");
    base = wrAddrLog.size();
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h11, 10);
    checkOutput("timeout not early", 32'(err), 32'd0);
    repeat (8) @(negedge clk);
    checkOutput("timeout err", 32'(err), 32'd1);
    checkOutput("timeout hold", 32'(cpuHold), 32'd1);
    checkOutput("timeout writes", 32'(wrAddrLog.size() - base), 32'd0);
    base = wrAddrLog.size();
    sendNominal(GOOD_CHK, 0);
    repeat (3) @(negedge clk);
    checkNominalWrites("after timeout", base);
    checkOutput("after timeout hold", 32'(cpuHold), 32'd0);

    // Valid toggling every other cycle.
    $display("[TB] gapped stream");
    base = wrAddrLog.size();
    doneBase = doneCount;
    sendNominal(GOOD_CHK, 1);
    repeat (3) @(negedge clk);
    checkNominalWrites("gapped", base);
    checkOutput("gapped done count", 32'(doneCount - doneBase), 32'd1);

    // Reset in the middle of the data phase.
    $display("[TB] reset mid-frame");
    base = wrAddrLog.size();
    for (int i = 0; i < 5; i++) applyStimulus(NOMINAL[i], 0);
    reset = 1'b1;
    #1;
    checkOutput("midreset outputs", {27'd0, inReady, wrEn, cpuHold, done, err}, 32'd0);
    checkOutput("midreset wr_data", wrData, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midreset writes", 32'(wrAddrLog.size() - base), 32'd0);
    checkOutput("midreset hold", 32'(cpuHold), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
